lateral_inhibition_arbiter: RTL and testbench

LATERAL_INHIBITION_ARBITER -- requirements
Module: lateral_inhibition_arbiter

---
 rtl/lateral_inhibition_arbiter_if.sv | 28 ++
 rtl/lateral_inhibition_arbiter.sv | 151 +++++++++++++++
 tb/tb_lateral_inhibition_arbiter.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/lateral_inhibition_arbiter_if.sv
// Competition bus between N neurons and the lateral inhibition arbiter.
// The neurons drive requests and potentials. The arbiter drives the registered responses.
interface lateral_inhibition_arbiter_if #(
  parameter int N = 8,
  parameter int W = 24
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic              start_core_img;
  logic [N-1:0]      start_li;
  logic [N*W-1:0]    potential;
  logic [N-1:0]      valid_li;
  logic [N-1:0]      won_lost;
  logic              li;
  logic [IW-1:0]     winner_idx;
  logic              busy;
  logic              err_drop;

  modport master (
    output start_core_img, start_li, potential,
    input  valid_li, won_lost, li, winner_idx, busy, err_drop
  );

  modport slave (
    input  start_core_img, start_li, potential,
    output valid_li, won_lost, li, winner_idx, busy, err_drop
  );
endinterface

// File: rtl/lateral_inhibition_arbiter.sv
// Winner-take-all arbiter. It collects neuron potentials and scans them one per cycle.
// The strongest neuron at or above threshold wins, and ties go to the lowest index.
module lateral_inhibition_arbiter #(
  parameter int                  N   = 8,
  parameter int                  W   = 24,
  parameter logic signed [W-1:0] TH  = W'(15018),
  parameter int                  TMO = 64
) (
  input  logic clk,
  input  logic rst,
  lateral_inhibition_arbiter_if.slave bus
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [7:0]    TMO_LAST = 8'(TMO - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  typedef enum logic [1:0] {IDLE, COLLECT, COMPARE, RESP} state_e;

  state_e                state_q, state_d;
  logic [N-1:0]          mask_q, mask_d;
  logic signed [W-1:0]   pot_q [N];
  logic signed [W-1:0]   pot_d [N];
  logic [7:0]            timer_q, timer_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [IW-1:0]         best_q, best_d;
  logic                  best_valid_q, best_valid_d;
  logic signed [W-1:0]   best_pot_q, best_pot_d;
  logic [N-1:0]          valid_q, valid_d;
  logic [N-1:0]          won_q, won_d;
  logic                  li_q, li_d;
  logic [IW-1:0]         widx_q, widx_d;
  logic                  busy_q, busy_d;
  logic                  err_q, err_d;
  logic signed [W-1:0]   cand;

  always_comb begin
    state_d      = state_q;
    mask_d       = mask_q;
    pot_d        = pot_q;
    timer_d      = timer_q;
    idx_d        = idx_q;
    best_d       = best_q;
    best_valid_d = best_valid_q;
    best_pot_d   = best_pot_q;
    valid_d      = '0;
    won_d        = '0;
    li_d         = li_q;
    widx_d       = widx_q;
    err_d        = err_q;
    cand         = pot_q[idx_q];

    if (bus.start_core_img) begin
      // A new image overrides everything, including same-cycle requests.
      state_d = IDLE;
      mask_d  = '0;
      li_d    = 1'b0;
      err_d   = 1'b0;
      widx_d  = '0;
    end else begin
      if (state_q == IDLE || state_q == COLLECT) begin
        for (int unsigned i = 0; i < N; i++) begin
          if (bus.start_li[i]) pot_d[i] = bus.potential[i*W +: W];
        end
        mask_d = mask_q | bus.start_li;
      end

      unique case (state_q)
        IDLE: begin
          if (|bus.start_li) begin
            timer_d = '0;
            state_d = COLLECT;
          end
        end
        COLLECT: begin
          if (&mask_q || timer_q == TMO_LAST) begin
            state_d      = COMPARE;
            idx_d        = '0;
            best_valid_d = 1'b0;
          end else begin
            timer_d = timer_q + 8'd1;
          end
        end
        COMPARE: begin
          if (|bus.start_li) err_d = 1'b1;
          if (mask_q[idx_q] && cand >= TH && (!best_valid_q || cand > best_pot_q)) begin
            best_d       = idx_q;
            best_pot_d   = cand;
            best_valid_d = 1'b1;
          end
          if (idx_q == LAST_IDX) state_d = RESP;
          else                   idx_d   = idx_q + 1'b1;
        end
        RESP: begin
          if (|bus.start_li) err_d = 1'b1;
          valid_d = mask_q;
          if (best_valid_q) begin
            won_d[best_q] = 1'b1;
            li_d          = 1'b1;
            widx_d        = best_q;
          end
          mask_d  = '0;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      mask_q       <= '0;
      pot_q        <= '{default: '0};
      timer_q      <= '0;
      idx_q        <= '0;
      best_q       <= '0;
      best_valid_q <= 1'b0;
      best_pot_q   <= '0;
      valid_q      <= '0;
      won_q        <= '0;
      li_q         <= 1'b0;
      widx_q       <= '0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      mask_q       <= mask_d;
      pot_q        <= pot_d;
      timer_q      <= timer_d;
      idx_q        <= idx_d;
      best_q       <= best_d;
      best_valid_q <= best_valid_d;
      best_pot_q   <= best_pot_d;
      valid_q      <= valid_d;
      won_q        <= won_d;
      li_q         <= li_d;
      widx_q       <= widx_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
    end
  end

  assign bus.valid_li   = valid_q;
  assign bus.won_lost   = won_q;
  assign bus.li         = li_q;
  assign bus.winner_idx = widx_q;
  assign bus.busy       = busy_q;
  assign bus.err_drop   = err_q;
endmodule

// File: tb/tb_lateral_inhibition_arbiter.sv
// Directed bench for lateral_inhibition_arbiter with N=8, W=24, TH=15018 and TMO=64.
// The expected values below are worked out by hand.
module tb_lateral_inhibition_arbiter;
  localparam int N = 8;
  localparam int W = 24;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;
  int   pv [8];

  always #5 clk = ~clk;

  lateral_inhibition_arbiter_if #(.N(N), .W(W)) bus ();

  lateral_inhibition_arbiter #(
    .N(N), .W(W), .TH(24'sd15018), .TMO(64)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load_pots();
    for (int i = 0; i < N; i++) bus.potential[i*W +: W] = 24'(pv[i]);
  endtask

  task automatic set_pots(input int a, b, c, d, e, f, g, h);
    pv[0] = a; pv[1] = b; pv[2] = c; pv[3] = d;
    pv[4] = e; pv[5] = f; pv[6] = g; pv[7] = h;
  endtask

  // The request pulse is sampled at edge t. Cycle k is the period after edge t+k.
  task automatic run_case(input string tag, input logic [7:0] req,
                          input int inj_cycle, input logic [7:0] inj_mask,
                          input int exp_cycles, input logic [7:0] exp_valid,
                          input logic [7:0] exp_won, input logic exp_li,
                          input logic [2:0] exp_widx);
    int cycles;
    load_pots();
    bus.start_li = req;
    @(negedge clk);
    bus.start_li = '0;
    cycles = 0;
    check({tag, "_busy"}, 32'(bus.busy), 32'd1);
    while (bus.valid_li == '0 && cycles < 300) begin
      if (cycles == inj_cycle) bus.start_li = inj_mask;
      @(negedge clk);
      bus.start_li = '0;
      cycles++;
    end
    check({tag, "_latency"}, 32'(cycles), 32'(exp_cycles));
    check({tag, "_valid"}, 32'(bus.valid_li), 32'(exp_valid));
    check({tag, "_won"}, 32'(bus.won_lost), 32'(exp_won));
    check({tag, "_li"}, 32'(bus.li), 32'(exp_li));
    check({tag, "_widx"}, 32'(bus.winner_idx), 32'(exp_widx));
    @(negedge clk);
    check({tag, "_pulse"}, 32'(bus.valid_li), 32'd0);
    check({tag, "_idle"}, 32'(bus.busy), 32'd0);
  endtask

  task automatic core_img(input logic [7:0] req);
    bus.start_core_img = 1'b1;
    bus.start_li       = req;
    @(negedge clk);
    bus.start_core_img = 1'b0;
    bus.start_li       = '0;
  endtask

  task automatic no_valid(input string tag, input int n);
    logic [7:0] acc = '0;
    repeat (n) begin
      @(negedge clk);
      acc |= bus.valid_li;
    end
    check(tag, 32'(acc), 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_valid"}, 32'(bus.valid_li), 32'd0);
    check({tag, "_won"}, 32'(bus.won_lost), 32'd0);
    check({tag, "_li"}, 32'(bus.li), 32'd0);
    check({tag, "_widx"}, 32'(bus.winner_idx), 32'd0);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_err"}, 32'(bus.err_drop), 32'd0);
  endtask

  initial begin
    rst                = 1'b1;
    bus.start_core_img = 1'b0;
    bus.start_li       = '0;
    bus.potential      = '0;
    repeat (2) @(negedge clk);
    check_reset_vals("rst");
    rst = 1'b0;
    @(negedge clk);

    // All eight neurons request. Neurons 2 and 3 tie at 20000, so the lower index (2) wins.
    set_pots(1000, 16000, 20000, 20000, 5000, 0, -3, 15018);
    run_case("allreq", 8'hFF, -1, 8'h00, 10, 8'hFF, 8'h04, 1'b1, 3'd2);

    // Only neurons 1 and 5 request, so the window closes on the timeout. 15018 is exactly TH.
    set_pots(0, 15018, 0, 0, 0, 14000, 0, 0);
    run_case("tmo", 8'h22, -1, 8'h00, 73, 8'h22, 8'h02, 1'b1, 3'd1);

    // No neuron qualifies, so li and winner_idx keep their values from the previous run.
    set_pots(100, 100, 100, 100, 100, 100, 100, 100);
    run_case("nonekeep", 8'hFF, -1, 8'h00, 10, 8'hFF, 8'h00, 1'b1, 3'd1);

    core_img(8'h00);
    check("img_li", 32'(bus.li), 32'd0);
    check("img_widx", 32'(bus.winner_idx), 32'd0);
    run_case("none", 8'hFF, -1, 8'h00, 10, 8'hFF, 8'h00, 1'b0, 3'd0);

    // Neuron 3 requests while the arbiter is in COMPARE. Its request is dropped.
    set_pots(1000, 16000, 20000, 20000, 5000, 0, -3, 15018);
    run_case("drop", 8'hF7, 66, 8'h08, 73, 8'hF7, 8'h04, 1'b1, 3'd2);
    check("drop_err", 32'(bus.err_drop), 32'd1);
    core_img(8'h00);
    check("dropclr_err", 32'(bus.err_drop), 32'd0);
    check("dropclr_li", 32'(bus.li), 32'd0);

    // start_core_img in the same cycle as start_li: the request is ignored and no error is flagged.
    core_img(8'hFF);
    check("imgwins_err", 32'(bus.err_drop), 32'd0);
    check("imgwins_busy", 32'(bus.busy), 32'd0);
    no_valid("imgwins_noresp", 20);

    // start_core_img while collecting abandons the competition.
    load_pots();
    bus.start_li = 8'hFF;
    @(negedge clk);
    bus.start_li       = '0;
    bus.start_core_img = 1'b1;
    @(negedge clk);
    bus.start_core_img = 1'b0;
    check("abort_busy", 32'(bus.busy), 32'd0);
    no_valid("abort_noresp", 20);

    // Second run: set li, cause a drop, then reset while in COMPARE.
    run_case("pre", 8'hFF, -1, 8'h00, 10, 8'hFF, 8'h04, 1'b1, 3'd2);
    bus.start_li = 8'hFF;
    @(negedge clk);
    bus.start_li = '0;
    repeat (2) @(negedge clk);
    bus.start_li = 8'h01;
    @(negedge clk);
    bus.start_li = '0;
    check("mid_err", 32'(bus.err_drop), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals("midrst");
    rst = 1'b0;
    no_valid("midrst_noresp", 20);
    check_reset_vals("postrst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
